// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retirement queue between the Tomasulo
// execution units and the register file. One rob_entry instance per slot;
// the top keeps head/tail/count, steers allocate/write-back/retire strobes
// to the slots, registers the commit port and answers operand lookups.

module rob_entry #(
  parameter int REG_TAG_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 alloc,
  input  logic [REG_TAG_W-1:0] alloc_dest_reg,
  input  logic                 alloc_is_store,
  input  logic                 alloc_is_branch,
  input  logic                 wb,
  input  logic [DATA_W-1:0]    wb_value,
  input  logic                 wb_mispredict,
  input  logic [DATA_W-1:0]    wb_target,
  output logic                 valid,
  output logic                 ready,
  output logic [REG_TAG_W-1:0] dest_reg,
  output logic [DATA_W-1:0]    value,
  output logic                 is_store,
  output logic                 is_branch,
  output logic                 mispredict,
  output logic [DATA_W-1:0]    target
);
  // Slot state: clear (retire/flush) beats allocate beats write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0; ready <= 1'b0; dest_reg <= '0; value <= '0;
      is_store <= 1'b0; is_branch <= 1'b0; mispredict <= 1'b0; target <= '0;
    end else if (rdy) begin
      if (clear) begin
        valid <= 1'b0;
        ready <= 1'b0;
      end else if (alloc) begin
        valid      <= 1'b1;
        ready      <= 1'b0;
        mispredict <= 1'b0;
        dest_reg   <= alloc_dest_reg;
        is_store   <= alloc_is_store;
        is_branch  <= alloc_is_branch;
      end else if (wb) begin
        ready      <= 1'b1;
        value      <= wb_value;
        mispredict <= wb_mispredict;
        target     <= wb_target;
      end
    end
  end
endmodule

module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_TAG_W = 5,
  parameter int REG_TAG_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_alloc_valid,
  input  logic [REG_TAG_W-1:0] in_alloc_dest_reg,
  input  logic                 in_alloc_is_store,
  input  logic                 in_alloc_is_branch,
  output logic [ROB_TAG_W-1:0] out_alloc_tag,
  output logic                 out_full,
  input  logic                 in_cdb_valid,
  input  logic [ROB_TAG_W-1:0] in_cdb_tag,
  input  logic [DATA_W-1:0]    in_cdb_value,
  input  logic                 in_cdb_mispredict,
  input  logic [DATA_W-1:0]    in_cdb_target,
  input  logic [ROB_TAG_W-1:0] in_query_tag1,
  input  logic [ROB_TAG_W-1:0] in_query_tag2,
  output logic                 out_query_ready1,
  output logic                 out_query_ready2,
  output logic [DATA_W-1:0]    out_query_value1,
  output logic [DATA_W-1:0]    out_query_value2,
  output logic [REG_TAG_W-1:0] out_commit_reg,
  output logic [ROB_TAG_W-1:0] out_commit_rob,
  output logic [DATA_W-1:0]    out_commit_value,
  output logic                 out_store_commit,
  output logic                 out_misbranch,
  output logic [DATA_W-1:0]    out_redirect_pc
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [ROB_SIZE-1:0]                e_valid, e_ready, e_store, e_branch, e_misp;
  logic [ROB_SIZE-1:0]                e_alloc, e_wb, e_clear;
  logic [ROB_SIZE-1:0][REG_TAG_W-1:0] e_dest;
  logic [ROB_SIZE-1:0][DATA_W-1:0]    e_value, e_target;

  logic commit_fire, flush, alloc_fire;

  // Commit is decided on registered head state; a mispredicted branch flushes.
  assign commit_fire = e_valid[head] && e_ready[head];
  assign flush       = commit_fire && e_branch[head] && e_misp[head];
  assign out_full    = (count == CNT_W'(ROB_SIZE));
  assign alloc_fire  = in_alloc_valid && !out_full && !flush;
  assign out_alloc_tag = ROB_TAG_W'(tail) + ROB_TAG_W'(1);

  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent
    assign e_alloc[i] = alloc_fire && (tail == IDX_W'(i));
    assign e_wb[i]    = in_cdb_valid && e_valid[i] && (in_cdb_tag == ROB_TAG_W'(i + 1));
    assign e_clear[i] = flush || (commit_fire && (head == IDX_W'(i)));

    rob_entry #(.REG_TAG_W(REG_TAG_W), .DATA_W(DATA_W)) u_ent (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(e_clear[i]),
      .alloc(e_alloc[i]), .alloc_dest_reg(in_alloc_dest_reg),
      .alloc_is_store(in_alloc_is_store), .alloc_is_branch(in_alloc_is_branch),
      .wb(e_wb[i]), .wb_value(in_cdb_value), .wb_mispredict(in_cdb_mispredict),
      .wb_target(in_cdb_target),
      .valid(e_valid[i]), .ready(e_ready[i]), .dest_reg(e_dest[i]),
      .value(e_value[i]), .is_store(e_store[i]), .is_branch(e_branch[i]),
      .mispredict(e_misp[i]), .target(e_target[i])
    );
  end

  // Pointer and occupancy bookkeeping; flush collapses the queue to empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0; tail <= '0; count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head <= '0; tail <= '0; count <= '0;
      end else begin
        if (commit_fire) head <= head + IDX_W'(1);
        if (alloc_fire)  tail <= tail + IDX_W'(1);
        case ({alloc_fire, commit_fire})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Registered commit port: one cycle after the commit decision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_commit_reg <= '0; out_commit_rob <= '0; out_commit_value <= '0;
      out_store_commit <= 1'b0; out_misbranch <= 1'b0; out_redirect_pc <= '0;
    end else if (rdy) begin
      out_commit_reg   <= commit_fire ? e_dest[head] : '0;
      out_commit_rob   <= commit_fire ? ROB_TAG_W'(head) + ROB_TAG_W'(1) : '0;
      out_commit_value <= commit_fire ? e_value[head] : '0;
      out_store_commit <= commit_fire && e_store[head];
      out_misbranch    <= flush;
      out_redirect_pc  <= flush ? e_target[head] : '0;
    end
  end

  logic [1:0][ROB_TAG_W-1:0] q_tag;
  logic [1:0][IDX_W-1:0]     q_idx;
  logic [1:0]                q_rdy;
  logic [1:0][DATA_W-1:0]    q_val;

  assign q_tag = {in_query_tag2, in_query_tag1};

  // Operand lookup: CDB bypass first, then a completed entry; tag 0 is "none".
  always_comb begin
    q_idx = '0;
    q_rdy = '0;
    q_val = '0;
    for (int q = 0; q < 2; q++) begin
      q_idx[q] = IDX_W'(q_tag[q] - ROB_TAG_W'(1));
      if (q_tag[q] != '0) begin
        if (in_cdb_valid && (in_cdb_tag == q_tag[q])) begin
          q_rdy[q] = 1'b1;
          q_val[q] = in_cdb_value;
        end else if (q_tag[q] <= ROB_TAG_W'(ROB_SIZE) &&
                     e_valid[q_idx[q]] && e_ready[q_idx[q]]) begin
          q_rdy[q] = 1'b1;
          q_val[q] = e_value[q_idx[q]];
        end
      end
    end
  end

  assign out_query_ready1 = q_rdy[0];
  assign out_query_ready2 = q_rdy[1];
  assign out_query_value1 = q_val[0];
  assign out_query_value2 = q_val[1];
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all
// checked against a queue-of-instructions model in program order.

module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_alloc_valid, in_alloc_is_store, in_alloc_is_branch;
  logic [4:0]  in_alloc_dest_reg;
  logic [4:0]  out_alloc_tag;
  logic        out_full;
  logic        in_cdb_valid, in_cdb_mispredict;
  logic [4:0]  in_cdb_tag;
  logic [31:0] in_cdb_value, in_cdb_target;
  logic [4:0]  in_query_tag1, in_query_tag2;
  logic        out_query_ready1, out_query_ready2;
  logic [31:0] out_query_value1, out_query_value2;
  logic [4:0]  out_commit_reg, out_commit_rob;
  logic [31:0] out_commit_value, out_redirect_pc;
  logic        out_store_commit, out_misbranch;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_alloc_valid(in_alloc_valid), .in_alloc_dest_reg(in_alloc_dest_reg),
    .in_alloc_is_store(in_alloc_is_store), .in_alloc_is_branch(in_alloc_is_branch),
    .out_alloc_tag(out_alloc_tag), .out_full(out_full),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_mispredict(in_cdb_mispredict), .in_cdb_target(in_cdb_target),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
    .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
    .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
    .out_commit_value(out_commit_value), .out_store_commit(out_store_commit),
    .out_misbranch(out_misbranch), .out_redirect_pc(out_redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          st, br, dn, misp;
    logic [31:0] val, tgt;
  } ent_t;

  ent_t        rob[$];
  int          next_tag = 1;
  logic [4:0]  e_reg, e_rob;
  logic [31:0] e_val, e_pc;
  bit          e_st, e_mis;
  int          checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected lookup result for one operand tag given current model + CDB.
  task automatic model_query(input int qt, output bit r, output logic [31:0] v);
    r = 0; v = 0;
    if (qt != 0) begin
      if (in_cdb_valid && in_cdb_tag == qt) begin
        r = 1; v = in_cdb_value;
      end else begin
        foreach (rob[i]) if (rob[i].tag == qt && rob[i].dn) begin r = 1; v = rob[i].val; end
      end
    end
  endtask

  // One clock edge of the model: commit from pre-edge state, then write-back,
  // retire, and allocate (or flush everything on a mispredicted branch).
  task automatic model_step();
    bit cm, fl;
    int n0;
    ent_t h, e;
    if (!rst) begin
      rob.delete(); next_tag = 1;
      e_reg = 0; e_rob = 0; e_val = 0; e_st = 0; e_mis = 0; e_pc = 0;
    end else if (rdy) begin
      n0 = rob.size();
      cm = (n0 > 0) && rob[0].dn;
      fl = 0;
      if (cm) begin
        h = rob[0];
        fl = h.br && h.misp;
        e_reg = h.dest; e_rob = 5'(h.tag); e_val = h.val; e_st = h.st;
        e_mis = fl; e_pc = h.tgt;
      end else begin
        e_reg = 0; e_rob = 0; e_st = 0; e_mis = 0;
      end
      if (in_cdb_valid)
        foreach (rob[i]) if (rob[i].tag == in_cdb_tag) begin
          rob[i].dn = 1; rob[i].val = in_cdb_value;
          rob[i].misp = in_cdb_mispredict; rob[i].tgt = in_cdb_target;
        end
      if (cm) void'(rob.pop_front());
      if (fl) begin
        rob.delete(); next_tag = 1;
      end else if (in_alloc_valid && n0 < 16) begin
        e.tag = next_tag; e.dest = in_alloc_dest_reg; e.st = in_alloc_is_store;
        e.br = in_alloc_is_branch; e.dn = 0; e.misp = 0; e.val = 0; e.tgt = 0;
        rob.push_back(e);
        next_tag = next_tag % 16 + 1;
      end
    end
  endtask

  // Inputs are already driven; check combinational outputs, clock, check registered ones.
  task automatic tick();
    bit r; logic [31:0] v;
    #1;
    chk("alloc_tag", out_alloc_tag, 64'(next_tag));
    chk("full", out_full, 64'(rob.size() == 16));
    model_query(in_query_tag1, r, v);
    chk("q1_ready", out_query_ready1, 64'(r));
    if (r) chk("q1_value", out_query_value1, v);
    model_query(in_query_tag2, r, v);
    chk("q2_ready", out_query_ready2, 64'(r));
    if (r) chk("q2_value", out_query_value2, v);
    @(posedge clk);
    model_step();
    #1;
    chk("commit_reg", out_commit_reg, e_reg);
    chk("commit_rob", out_commit_rob, e_rob);
    chk("store_commit", out_store_commit, 64'(e_st));
    chk("misbranch", out_misbranch, 64'(e_mis));
    if (e_rob != 0) chk("commit_value", out_commit_value, e_val);
    if (e_mis) chk("redirect_pc", out_redirect_pc, e_pc);
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 1; rdy = 1;
    in_alloc_valid = 0; in_alloc_dest_reg = 0; in_alloc_is_store = 0; in_alloc_is_branch = 0;
    in_cdb_valid = 0; in_cdb_tag = 0; in_cdb_value = 0; in_cdb_mispredict = 0; in_cdb_target = 0;
    in_query_tag1 = 0; in_query_tag2 = 0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 0; tick(); tick(); rst = 1;
  endtask

  task automatic alloc(input logic [4:0] d, input bit st, input bit br);
    idle_in(); in_alloc_valid = 1; in_alloc_dest_reg = d;
    in_alloc_is_store = st; in_alloc_is_branch = br; tick();
  endtask

  task automatic cdb(input int t, input logic [31:0] v, input bit mp, input logic [31:0] tg);
    idle_in(); in_cdb_valid = 1; in_cdb_tag = 5'(t); in_cdb_value = v;
    in_cdb_mispredict = mp; in_cdb_target = tg; tick();
  endtask

  initial begin
    int cand[$];
    int k;
    idle_in();
    @(negedge clk);
    do_reset();
    chk("rst_alloc_tag", out_alloc_tag, 1);
    chk("rst_commit_reg", out_commit_reg, 0);

    // Single instruction round trip.
    alloc(5, 0, 0);
    chk("tag_after_alloc", out_alloc_tag, 2);
    cdb(1, 32'h2A, 0, 0);
    idle_in(); tick();
    chk("first_commit_val", out_commit_value, 32'h2A);
    idle_in(); tick();

    // Out-of-order completion retires in order.
    alloc(1, 0, 0); alloc(2, 0, 0); alloc(3, 0, 0);
    cdb(4, 32'h33, 0, 0); cdb(3, 32'h22, 0, 0); cdb(2, 32'h11, 0, 0);
    for (int i = 0; i < 4; i++) begin idle_in(); tick(); end

    // Fill, reject, drain one, wrap.
    do_reset();
    for (int i = 0; i < 17; i++) alloc(5'(i + 1), 0, 0);
    chk("full_after_16", out_full, 1);
    cdb(1, 32'h5, 0, 0);
    idle_in(); tick();
    chk("not_full_after_commit", out_full, 0);
    alloc(9, 0, 0);

    // Mispredicted branch flushes younger ready entries; query bypass.
    do_reset();
    alloc(1, 0, 0); alloc(0, 0, 1); alloc(3, 0, 0); alloc(4, 0, 0);
    idle_in(); in_cdb_valid = 1; in_cdb_tag = 4; in_cdb_value = 32'h77;
    in_query_tag1 = 4; in_query_tag2 = 0; tick();
    cdb(3, 32'h66, 0, 0);
    cdb(2, 32'h0, 1, 32'h1000);
    cdb(1, 32'h1, 0, 0);
    idle_in(); tick();
    idle_in(); tick();
    chk("misbranch_pulse", out_misbranch, 1);
    chk("redirect", out_redirect_pc, 32'h1000);
    idle_in(); tick();
    chk("misbranch_low", out_misbranch, 0);
    chk("tag_after_flush", out_alloc_tag, 1);

    // Store commit, then rdy freeze mid-stream.
    alloc(0, 1, 0); alloc(7, 0, 0);
    cdb(1, 32'h9, 0, 0); cdb(2, 32'hA, 0, 0);
    idle_in(); rdy = 0; tick(); tick(); tick();
    idle_in(); tick(); tick(); tick();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      idle_in();
      rst = ($urandom_range(0, 299) != 0);
      rdy = ($urandom_range(0, 9) != 0);
      in_alloc_valid = ($urandom_range(0, 9) < 6);
      in_alloc_is_store = ($urandom_range(0, 5) == 0);
      in_alloc_is_branch = !in_alloc_is_store && ($urandom_range(0, 4) == 0);
      in_alloc_dest_reg = in_alloc_is_store ? 5'd0 : 5'($urandom);
      cand.delete();
      foreach (rob[i]) if (!rob[i].dn) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 7) begin
        k = cand[$urandom_range(0, cand.size() - 1)];
        in_cdb_valid = 1; in_cdb_tag = 5'(rob[k].tag);
        in_cdb_mispredict = rob[k].br && ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 4) == 0) begin
        in_cdb_valid = 1; in_cdb_tag = 5'($urandom);
      end
      in_cdb_value = $urandom; in_cdb_target = $urandom;
      in_query_tag1 = 5'($urandom_range(0, 17));
      in_query_tag2 = ($urandom_range(0, 1) == 0) ? in_cdb_tag : 5'($urandom_range(0, 17));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
